// File: rtl/cpu16_pkg.sv
// cpu16_pkg: shared opcode, ALUOp, mux-select and control-state definitions for the 16-bit CPU.
package cpu16_pkg;
    localparam logic [3:0] OP_RTYPE = 4'h0;
    localparam logic [3:0] OP_LW    = 4'h1;
    localparam logic [3:0] OP_SW    = 4'h2;
    localparam logic [3:0] OP_BEQ   = 4'h3;
    localparam logic [3:0] OP_ADDI  = 4'h4;
    localparam logic [3:0] OP_SLTI  = 4'h5;
    localparam logic [3:0] OP_J     = 4'h6;

    localparam logic [1:0] ALUOP_FUNC = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_SLT  = 2'b10;
    localparam logic [1:0] ALUOP_ADD  = 2'b11;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_INC    = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_R_WB, S_MEM_ADDR, S_MEM_RD,
        S_MEM_WB, S_MEM_WR, S_EXEC_I, S_I_WB, S_BRANCH, S_JUMP, S_ILLEGAL
    } state_t;
endpackage

// File: rtl/main_control_decode.sv
// main_control_decode: combinational state-to-control-signal decode for the main control FSM.
module main_control_decode
    import cpu16_pkg::*;
#(
    parameter logic [1:0] PC_INC_SEL = 2'b01
) (
    input  state_t     i_state,
    input  logic [3:0] i_opcode,
    input  logic       i_mem_ready,
    output logic       o_ir_write,
    output logic       o_pc_write,
    output logic       o_pc_write_cond,
    output logic [1:0] o_pc_src,
    output logic       o_iord,
    output logic       o_mem_read,
    output logic       o_mem_write,
    output logic       o_mem_to_reg,
    output logic       o_reg_write,
    output logic       o_reg_dst,
    output logic       o_alu_src_a,
    output logic [1:0] o_alu_src_b,
    output logic [1:0] o_alu_op,
    output logic       o_illegal,
    output logic       o_instr_done
);
    always_comb begin
        o_ir_write      = 1'b0;
        o_pc_write      = 1'b0;
        o_pc_write_cond = 1'b0;
        o_pc_src        = PCSRC_ALU;
        o_iord          = 1'b0;
        o_mem_read      = 1'b0;
        o_mem_write     = 1'b0;
        o_mem_to_reg    = 1'b0;
        o_reg_write     = 1'b0;
        o_reg_dst       = 1'b0;
        o_alu_src_a     = 1'b0;
        o_alu_src_b     = SRCB_B;
        o_alu_op        = ALUOP_FUNC;
        o_illegal       = 1'b0;
        o_instr_done    = 1'b0;
        case (i_state)
            S_FETCH: begin
                o_mem_read  = 1'b1;
                o_alu_src_b = PC_INC_SEL;
                o_alu_op    = ALUOP_ADD;
                o_ir_write  = i_mem_ready;
                o_pc_write  = i_mem_ready;
            end
            S_DECODE: begin
                o_alu_src_b = SRCB_IMM_SH;
                o_alu_op    = ALUOP_ADD;
            end
            S_EXEC_R: o_alu_src_a = 1'b1;
            S_R_WB: begin
                o_reg_dst    = 1'b1;
                o_reg_write  = 1'b1;
                o_instr_done = 1'b1;
            end
            S_MEM_ADDR: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = SRCB_IMM;
                o_alu_op    = ALUOP_ADD;
            end
            S_MEM_RD: begin
                o_mem_read = 1'b1;
                o_iord     = 1'b1;
            end
            S_MEM_WB: begin
                o_mem_to_reg = 1'b1;
                o_reg_write  = 1'b1;
                o_instr_done = 1'b1;
            end
            S_MEM_WR: begin
                o_mem_write  = 1'b1;
                o_iord       = 1'b1;
                o_instr_done = i_mem_ready;
            end
            S_EXEC_I: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = SRCB_IMM;
                o_alu_op    = (i_opcode == OP_SLTI) ? ALUOP_SLT : ALUOP_ADD;
            end
            S_I_WB: begin
                o_reg_write  = 1'b1;
                o_instr_done = 1'b1;
            end
            S_BRANCH: begin
                o_alu_src_a     = 1'b1;
                o_alu_op        = ALUOP_SUB;
                o_pc_write_cond = 1'b1;
                o_pc_src        = PCSRC_ALUOUT;
                o_instr_done    = 1'b1;
            end
            S_JUMP: begin
                o_pc_write   = 1'b1;
                o_pc_src     = PCSRC_JUMP;
                o_instr_done = 1'b1;
            end
            S_ILLEGAL: begin
                o_illegal    = 1'b1;
                o_instr_done = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/main_control_fsm.sv
// main_control_fsm: multi-cycle main control unit; holds the state register and next-state logic.
module main_control_fsm
    import cpu16_pkg::*;
#(
    parameter logic [1:0] PC_INC_SEL = 2'b01
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] opcode,
    input  logic       mem_ready,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic [1:0] pc_src,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       illegal,
    output logic       instr_done
);
    state_t r_state;
    state_t w_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Encodings outside the enumeration fall through to IDLE.
    always_comb begin
        w_next = S_IDLE;
        case (r_state)
            S_IDLE:     w_next = S_FETCH;
            S_FETCH:    w_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:       w_next = S_EXEC_R;
                    OP_LW, OP_SW:   w_next = S_MEM_ADDR;
                    OP_ADDI, OP_SLTI: w_next = S_EXEC_I;
                    OP_BEQ:         w_next = S_BRANCH;
                    OP_J:           w_next = S_JUMP;
                    default:        w_next = S_ILLEGAL;
                endcase
            end
            S_EXEC_R:   w_next = S_R_WB;
            S_MEM_ADDR: w_next = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   w_next = mem_ready ? S_MEM_WB : S_MEM_RD;
            S_MEM_WR:   w_next = mem_ready ? S_FETCH : S_MEM_WR;
            S_EXEC_I:   w_next = S_I_WB;
            S_R_WB, S_MEM_WB, S_I_WB, S_BRANCH, S_JUMP, S_ILLEGAL: w_next = S_FETCH;
            default:    w_next = S_IDLE;
        endcase
    end

    main_control_decode #(.PC_INC_SEL(PC_INC_SEL)) u_decode (
        .i_state        (r_state),
        .i_opcode       (opcode),
        .i_mem_ready    (mem_ready),
        .o_ir_write     (ir_write),
        .o_pc_write     (pc_write),
        .o_pc_write_cond(pc_write_cond),
        .o_pc_src       (pc_src),
        .o_iord         (iord),
        .o_mem_read     (mem_read),
        .o_mem_write    (mem_write),
        .o_mem_to_reg   (mem_to_reg),
        .o_reg_write    (reg_write),
        .o_reg_dst      (reg_dst),
        .o_alu_src_a    (alu_src_a),
        .o_alu_src_b    (alu_src_b),
        .o_alu_op       (alu_op),
        .o_illegal      (illegal),
        .o_instr_done   (instr_done)
    );
endmodule
